// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. It handles load-use bubbles,
// memory busywait freezes and branch-redirect squashes. It also keeps saturating
// stall and flush event counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       rs1_label_if_id_i,
  input  logic [4:0]       rs2_label_if_id_i,
  input  logic             uses_rs1_i,
  input  logic             uses_rs2_i,
  input  logic [4:0]       rd_id_ex_i,
  input  logic             is_load_instr_id_ex_i,
  input  logic             reg_wb_en_id_ex_i,
  input  logic             branch_taken_ex_i,
  input  logic             imem_busywait_i,
  input  logic             dmem_busywait_i,
  output logic             pc_write_en_o,
  output logic             stall_if_id_o,
  output logic             busywait_id_ex_o,
  output logic             busywait_ex_mem_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [3:0]       LU_INIT = 4'(LOAD_STALL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [3:0]       lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use;
  logic             flush_evt;

  // Performance counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // An ID instruction needs a register that the load now in EX has not yet
  // produced. Register x0 never causes a hazard.
  assign load_use = is_load_instr_id_ex_i & reg_wb_en_id_ex_i & (rd_id_ex_i != 5'd0) &
                    ((uses_rs1_i & (rs1_label_if_id_i == rd_id_ex_i)) |
                     (uses_rs2_i & (rs2_label_if_id_i == rd_id_ex_i)));

  // Next-state and stage-control decode. Priority is data wait, then branch,
  // then load-use, then fetch wait.
  always_comb begin
    state_d           = RUN;
    lu_cnt_d          = lu_cnt_q;
    flush_evt         = 1'b0;
    pc_write_en_o     = 1'b1;
    stall_if_id_o     = 1'b0;
    busywait_id_ex_o  = 1'b0;
    busywait_ex_mem_o = 1'b0;
    flush_if_id_o     = 1'b0;
    flush_id_ex_o     = 1'b0;
    if (!rst_ni) begin
      pc_write_en_o = 1'b0;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end else if (state_q == REDIRECT) begin
      // The wrong-path fetch still in flight is squashed. The PC is held until
      // that fetch completes.
      flush_if_id_o     = 1'b1;
      flush_id_ex_o     = 1'b1;
      busywait_ex_mem_o = dmem_busywait_i;
      pc_write_en_o     = ~imem_busywait_i;
      state_d           = imem_busywait_i ? REDIRECT : RUN;
    end else if (dmem_busywait_i) begin
      pc_write_en_o     = 1'b0;
      stall_if_id_o     = 1'b1;
      busywait_id_ex_o  = 1'b1;
      busywait_ex_mem_o = 1'b1;
      state_d           = (state_q == LU_STALL) ? LU_STALL : MEM_WAIT;
    end else if (branch_taken_ex_i) begin
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      flush_evt     = 1'b1;
      state_d       = imem_busywait_i ? REDIRECT : RUN;
    end else if (state_q == LU_STALL) begin
      pc_write_en_o = 1'b0;
      stall_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      lu_cnt_d      = lu_cnt_q - 4'd1;
      state_d       = (lu_cnt_q == 4'd1) ? RUN : LU_STALL;
    end else if (load_use) begin
      pc_write_en_o = 1'b0;
      stall_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      if (LOAD_STALL_CYC > 1) begin
        lu_cnt_d = LU_INIT;
        state_d  = LU_STALL;
      end
    end else if (imem_busywait_i) begin
      pc_write_en_o = 1'b0;
      stall_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end
  end

  // State, bubble countdown and event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      lu_cnt_q    <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      if (!pc_write_en_o) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_evt)      flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Instance a uses the default
// parameters. Instance b uses a 3-cycle load bubble and 4-bit counters.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, is_load, wb_en, br, imem, dmem;

  logic        a_pc, a_st, a_bie, a_bem, a_fif, a_fie;
  logic [1:0]  a_state;
  logic [31:0] a_scnt, a_fcnt;
  logic        b_pc, b_st, b_bie, b_bem, b_fif, b_fie;
  logic [1:0]  b_state;
  logic [3:0]  b_scnt, b_fcnt;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [5:0] C_DEF   = 6'b100000;
  localparam logic [5:0] C_STALL = 6'b010001;
  localparam logic [5:0] C_FRZ   = 6'b011100;
  localparam logic [5:0] C_FLUSH = 6'b100011;
  localparam logic [5:0] C_HOLD  = 6'b000011;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_label_if_id_i(rs1), .rs2_label_if_id_i(rs2),
    .uses_rs1_i(u1), .uses_rs2_i(u2), .rd_id_ex_i(rd),
    .is_load_instr_id_ex_i(is_load), .reg_wb_en_id_ex_i(wb_en),
    .branch_taken_ex_i(br), .imem_busywait_i(imem), .dmem_busywait_i(dmem),
    .pc_write_en_o(a_pc), .stall_if_id_o(a_st), .busywait_id_ex_o(a_bie),
    .busywait_ex_mem_o(a_bem), .flush_if_id_o(a_fif), .flush_id_ex_o(a_fie),
    .state_o(a_state), .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYC(3), .CNT_W(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_label_if_id_i(rs1), .rs2_label_if_id_i(rs2),
    .uses_rs1_i(u1), .uses_rs2_i(u2), .rd_id_ex_i(rd),
    .is_load_instr_id_ex_i(is_load), .reg_wb_en_id_ex_i(wb_en),
    .branch_taken_ex_i(br), .imem_busywait_i(imem), .dmem_busywait_i(dmem),
    .pc_write_en_o(b_pc), .stall_if_id_o(b_st), .busywait_id_ex_o(b_bie),
    .busywait_ex_mem_o(b_bem), .flush_if_id_o(b_fif), .flush_id_ex_o(b_fie),
    .state_o(b_state), .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; u1 = 1'b0; u2 = 1'b0;
    is_load = 1'b0; wb_en = 1'b0; br = 1'b0; imem = 1'b0; dmem = 1'b0;
  endtask

  function automatic logic [31:0] ctl_a();
    return {26'd0, a_pc, a_st, a_bie, a_bem, a_fif, a_fie};
  endfunction

  function automatic logic [31:0] ctl_b();
    return {26'd0, b_pc, b_st, b_bie, b_bem, b_fif, b_fie};
  endfunction

  initial begin
    clear_in();
    rst_n = 1'b0;
    #2;
    chk("rst_ctl_a", ctl_a(), {26'd0, C_HOLD});
    chk("rst_state_a", {30'd0, a_state}, 32'd0);
    chk("rst_scnt_a", a_scnt, 32'd0);
    chk("rst_fcnt_a", a_fcnt, 32'd0);
    #1 rst_n = 1'b1;
    #1;
    chk("idle_ctl_a", ctl_a(), {26'd0, C_DEF});
    tick();

    // Load-use through rs2 (rd=5)
    is_load = 1'b1; wb_en = 1'b1; rd = 5'd5; u2 = 1'b1; rs2 = 5'd5;
    #1;
    chk("lu_ctl_a", ctl_a(), {26'd0, C_STALL});
    chk("lu_ctl_b", ctl_b(), {26'd0, C_STALL});
    tick();
    clear_in();
    #1;
    chk("lu_after_ctl_a", ctl_a(), {26'd0, C_DEF});
    chk("lu_after_state_a", {30'd0, a_state}, 32'd0);
    chk("lu_scnt_a", a_scnt, 32'd1);
    chk("lu3_state_b1", {30'd0, b_state}, 32'd1);
    chk("lu3_ctl_b1", ctl_b(), {26'd0, C_STALL});
    tick();
    chk("lu3_state_b2", {30'd0, b_state}, 32'd1);
    chk("lu3_ctl_b2", ctl_b(), {26'd0, C_STALL});
    tick();
    chk("lu3_state_b3", {30'd0, b_state}, 32'd0);
    chk("lu3_ctl_b3", ctl_b(), {26'd0, C_DEF});
    chk("lu3_scnt_b", {28'd0, b_scnt}, 32'd3);

    // Same load pattern with rd=0 never stalls
    is_load = 1'b1; wb_en = 1'b1; rd = 5'd0; u1 = 1'b1; rs1 = 5'd0;
    #1;
    chk("rd0_ctl_a", ctl_a(), {26'd0, C_DEF});
    tick();
    chk("rd0_scnt_a", a_scnt, 32'd1);

    // Load-use via rs1, then a 2-cycle data wait inside LU_STALL
    clear_in();
    is_load = 1'b1; wb_en = 1'b1; rd = 5'd7; u1 = 1'b1; rs1 = 5'd7;
    tick();
    clear_in();
    dmem = 1'b1;
    #1;
    chk("dw_ctl_b1", ctl_b(), {26'd0, C_FRZ});
    chk("dw_state_b1", {30'd0, b_state}, 32'd1);
    chk("dw_ctl_a1", ctl_a(), {26'd0, C_FRZ});
    tick();
    chk("dw_ctl_b2", ctl_b(), {26'd0, C_FRZ});
    chk("dw_state_a2", {30'd0, a_state}, 32'd2);
    tick();
    dmem = 1'b0;
    #1;
    chk("dw_rel_ctl_b", ctl_b(), {26'd0, C_STALL});
    chk("dw_rel_state_b", {30'd0, b_state}, 32'd1);
    chk("dw_rel_ctl_a", ctl_a(), {26'd0, C_DEF});
    tick();
    chk("dw_lu_state_b", {30'd0, b_state}, 32'd1);
    chk("dw_lu_ctl_b", ctl_b(), {26'd0, C_STALL});
    chk("dw_rel_state_a", {30'd0, a_state}, 32'd0);
    tick();
    chk("dw_end_state_b", {30'd0, b_state}, 32'd0);
    chk("dw_scnt_b", {28'd0, b_scnt}, 32'd8);
    chk("dw_scnt_a", a_scnt, 32'd4);

    // Branch with fetch complete: one flush cycle, state stays RUN
    br = 1'b1;
    #1;
    chk("br_ctl_a", ctl_a(), {26'd0, C_FLUSH});
    tick();
    br = 1'b0;
    #1;
    chk("br_fcnt_a", a_fcnt, 32'd1);
    chk("br_state_a", {30'd0, a_state}, 32'd0);
    chk("br_after_ctl_a", ctl_a(), {26'd0, C_DEF});

    // Branch while fetch busy: three REDIRECT cycles, then release
    br = 1'b1; imem = 1'b1;
    #1;
    chk("rd_br_ctl_a", ctl_a(), {26'd0, C_FLUSH});
    tick();
    br = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rd_hold_state_a", {30'd0, a_state}, 32'd3);
      chk("rd_hold_ctl_a", ctl_a(), {26'd0, C_HOLD});
      tick();
    end
    imem = 1'b0;
    #1;
    chk("rd_rel_state_a", {30'd0, a_state}, 32'd3);
    chk("rd_rel_ctl_a", ctl_a(), {26'd0, C_FLUSH});
    tick();
    chk("rd_run_state_a", {30'd0, a_state}, 32'd0);
    chk("rd_run_ctl_a", ctl_a(), {26'd0, C_DEF});
    chk("rd_fcnt_a", a_fcnt, 32'd2);
    chk("rd_scnt_a", a_scnt, 32'd7);

    // Data wait, branch and load-use together: only the freeze until dmem drops
    dmem = 1'b1; br = 1'b1;
    is_load = 1'b1; wb_en = 1'b1; rd = 5'd5; u2 = 1'b1; rs2 = 5'd5;
    #1;
    chk("all_ctl_a1", ctl_a(), {26'd0, C_FRZ});
    tick();
    chk("all_ctl_a2", ctl_a(), {26'd0, C_FRZ});
    chk("all_fcnt_a2", a_fcnt, 32'd2);
    tick();
    dmem = 1'b0;
    #1;
    chk("all_br_ctl_a", ctl_a(), {26'd0, C_FLUSH});
    tick();
    clear_in();
    #1;
    chk("all_fcnt_a", a_fcnt, 32'd3);
    chk("all_state_a", {30'd0, a_state}, 32'd0);
    chk("all_scnt_a", a_scnt, 32'd9);

    // Asynchronous reset while in REDIRECT
    br = 1'b1; imem = 1'b1;
    tick();
    br = 1'b0;
    chk("ar_pre_state_a", {30'd0, a_state}, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_state_a", {30'd0, a_state}, 32'd0);
    chk("ar_scnt_a", a_scnt, 32'd0);
    chk("ar_fcnt_a", a_fcnt, 32'd0);
    chk("ar_ctl_a", ctl_a(), {26'd0, C_HOLD});
    tick();
    chk("ar_hold_ctl_a", ctl_a(), {26'd0, C_HOLD});
    chk("ar_hold_scnt_b", {28'd0, b_scnt}, 32'd0);

    // 20 fetch-stall cycles: the 4-bit counter saturates at 15
    clear_in();
    imem = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("im_ctl_a", ctl_a(), {26'd0, C_STALL});
    for (int i = 0; i < 20; i++) tick();
    chk("sat_scnt_b", {28'd0, b_scnt}, 32'd15);
    chk("sat_scnt_a", a_scnt, 32'd20);
    imem = 1'b0;
    tick();
    chk("sat_hold_scnt_b", {28'd0, b_scnt}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
